// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - packs decoded instruction fields into RAM words, then starts the processor
module prog_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int START_DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [15:0]       in_valC,
    input  logic              in_last,
    input  logic              reload,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [31:0]       wdata,
    output logic              working,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam int WAIT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_M1  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_DELAY - 1);

    typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_WAIT, S_RUN} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr, w_ptr_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [ADDR_W:0]   r_count, w_count_next;
    logic              r_wr, w_wr_next;
    logic              r_ovf, w_ovf_next;
    logic [31:0]       r_wdata, w_wdata_next;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic              w_ready, w_xfer, w_final;

    assign w_ready = (r_state == S_LOAD) && (r_count < DEPTH_C);
    assign w_xfer  = in_valid && w_ready;
    // Filling the last slot ends the program even without in_last.
    assign w_final = in_last || (r_count == DEPTH_M1);

    assign in_ready = w_ready && !reset;
    assign addr     = r_addr;
    assign wr       = r_wr;
    assign wdata    = r_wdata;
    assign working  = (r_state == S_RUN);
    assign count    = r_count;
    assign overflow = r_ovf;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_addr_next  = r_addr;
        w_count_next = r_count;
        w_wr_next    = 1'b0;
        w_wdata_next = r_wdata;
        w_wait_next  = r_wait;
        w_ovf_next   = r_ovf || (in_valid && !w_ready);
        case (r_state)
            S_LOAD: begin
                if (w_xfer) begin
                    w_wr_next    = 1'b1;
                    w_addr_next  = r_ptr;
                    w_wdata_next = {in_icode, in_ifun, in_rA, in_rB, in_valC};
                    w_ptr_next   = r_ptr + ADDR_W'(1);
                    w_count_next = r_count + (ADDR_W+1)'(1);
                    if (w_final) begin
                        w_state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_state_next = S_WAIT;
                w_addr_next  = '0;
                w_wdata_next = '0;
                w_wait_next  = '0;
            end
            S_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_state_next = S_RUN;
                end else begin
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            S_RUN: begin
                if (reload) begin
                    w_state_next = S_LOAD;
                    w_ptr_next   = '0;
                    w_count_next = '0;
                    w_ovf_next   = 1'b0;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_addr  <= w_addr_next;
            r_count <= w_count_next;
            r_wr    <= w_wr_next;
            r_wdata <= w_wdata_next;
            r_wait  <= w_wait_next;
            r_ovf   <= w_ovf_next;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;
    localparam int SD      = 2;
    localparam int B_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [3:0]  in_icode = '0, in_ifun = '0, in_rA = '0, in_rB = '0;
    logic [15:0] in_valC = '0;
    logic        in_last = 1'b0, reload = 1'b0;

    logic        in_ready_a, wr_a, working_a, overflow_a;
    logic [8:0]  addr_a;
    logic [31:0] wdata_a;
    logic [9:0]  count_a;
    logic        in_ready_b, wr_b, working_b, overflow_b;
    logic [8:0]  addr_b;
    logic [31:0] wdata_b;
    logic [9:0]  count_b;

    int checks = 0, failures = 0, cyc = 0;

    prog_loader #(.ADDR_W(9), .DEPTH(512), .START_DELAY(SD)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_last(in_last), .reload(reload),
        .addr(addr_a), .wr(wr_a), .wdata(wdata_a), .working(working_a),
        .count(count_a), .overflow(overflow_a)
    );

    prog_loader #(.ADDR_W(9), .DEPTH(B_DEPTH), .START_DELAY(SD)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_last(in_last), .reload(reload),
        .addr(addr_b), .wr(wr_b), .wdata(wdata_b), .working(working_b),
        .count(count_b), .overflow(overflow_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Write/start monitors: every RAM write strobe and the first working edge.
    int unsigned mon_addr_a[$], mon_data_a[$], mon_addr_b[$], mon_data_b[$];
    int          mon_cyc_a[$], mon_cyc_b[$];
    int          work_cyc_a = -1, work_cyc_b = -1;
    logic        prev_work_a = 1'b0, prev_work_b = 1'b0;

    always @(negedge clock) begin
        if (wr_a) begin
            mon_addr_a.push_back(addr_a);
            mon_data_a.push_back(wdata_a);
            mon_cyc_a.push_back(cyc);
        end
        if (working_a && !prev_work_a && work_cyc_a < 0) work_cyc_a = cyc;
        prev_work_a = working_a;
        if (wr_b) begin
            mon_addr_b.push_back(addr_b);
            mon_data_b.push_back(wdata_b);
            mon_cyc_b.push_back(cyc);
        end
        if (working_b && !prev_work_b && work_cyc_b < 0) work_cyc_b = cyc;
        prev_work_b = working_b;
    end

    logic [3:0]  p_ic[16], p_if[16], p_ra[16], p_rb[16];
    logic [15:0] p_vc[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pack(input int k);
        int unsigned v;
        v = 32'(p_ic[k]);
        v = v * 16 + 32'(p_if[k]);
        v = v * 16 + 32'(p_ra[k]);
        v = v * 16 + 32'(p_rb[k]);
        v = v * 65536 + 32'(p_vc[k]);
        return v;
    endfunction

    task automatic rand_fields();
        for (int k = 0; k < 16; k++) begin
            p_ic[k] = 4'($urandom);
            p_if[k] = 4'($urandom);
            p_ra[k] = 4'($urandom);
            p_rb[k] = 4'($urandom);
            p_vc[k] = 16'($urandom);
        end
    endtask

    task automatic drive_fields(input int k, input logic last);
        in_icode = p_ic[k];
        in_ifun  = p_if[k];
        in_rA    = p_ra[k];
        in_rB    = p_rb[k];
        in_valC  = p_vc[k];
        in_last  = last;
    endtask

    // gap_mode: 0 back-to-back, 1 one bundle every 3 cycles, 2 random gaps
    task automatic load_prog(input int n, input int gap_mode, input bit poke_wait);
        int exp_cyc[$];
        int stalls = 0;
        int gap;
        bit timeout = 0;
        mon_addr_a.delete(); mon_data_a.delete(); mon_cyc_a.delete();
        work_cyc_a = -1;
        for (int k = 0; k < n; k++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
            if (gap > 0) begin
                in_valid_a = 1'b0;
                repeat (gap) @(negedge clock);
            end
            drive_fields(k, k == n - 1);
            in_valid_a = 1'b1;
            while (!in_ready_a) begin
                stalls++;
                if (stalls > 50) begin timeout = 1; break; end
                @(negedge clock);
            end
            if (timeout) break;
            exp_cyc.push_back(cyc + 1);
            @(negedge clock);
        end
        in_valid_a = 1'b0;
        in_last = 1'b0;
        chk("ready_stalls", stalls, 0);
        if (poke_wait) begin
            @(negedge clock);
            in_valid_a = 1'b1;
            @(negedge clock);
            in_valid_a = 1'b0;
        end
        for (int t = 0; t < 40 && work_cyc_a < 0; t++) @(negedge clock);
        chk("write_count", mon_addr_a.size(), n);
        for (int k = 0; k < n && k < mon_addr_a.size() && k < exp_cyc.size(); k++) begin
            chk($sformatf("addr[%0d]", k), mon_addr_a[k], k);
            chk($sformatf("wdata[%0d]", k), mon_data_a[k], pack(k));
            chk($sformatf("wr_cycle[%0d]", k), mon_cyc_a[k], exp_cyc[k]);
        end
        if (exp_cyc.size() > 0) chk("working_cycle", work_cyc_a, exp_cyc[exp_cyc.size()-1] + SD + 1);
        chk("count", count_a, n);
        chk("overflow", overflow_a, poke_wait);
        chk("run_working", working_a, 1);
        chk("run_wr", wr_a, 0);
        chk("run_addr", addr_a, 0);
    endtask

    task automatic do_reload();
        chk("pre_reload_working", working_a, 1);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        chk("reload_working", working_a, 0);
        chk("reload_count", count_a, 0);
        chk("reload_overflow", overflow_a, 0);
        chk("reload_ready", in_ready_a, 1);
    endtask

    int unsigned tp1_words[5] = '{32'h10F00010, 32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000};

    initial begin
        bit found;
        int k, kb, acc_b, cyc0;

        repeat (2) @(negedge clock);
        chk("rst_addr", addr_a, 0);
        chk("rst_wr", wr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_working", working_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_overflow", overflow_a, 0);
        chk("rst_ready", in_ready_a, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", in_ready_a, 1);

        p_ic[0:4] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
        p_if[0:4] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
        p_ra[0:4] = '{4'hF, 4'h0, 4'h2, 4'h4, 4'h6};
        p_rb[0:4] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h7};
        p_vc[0:4] = '{16'h0010, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(5, 0, 0);
        for (int i = 0; i < 5 && i < mon_data_a.size(); i++)
            chk($sformatf("tp1_word[%0d]", i), mon_data_a[i], tp1_words[i]);
        do_reload();

        rand_fields();
        load_prog(3, 1, 0);
        do_reload();

        rand_fields();
        p_vc[0] = 16'hAAAA;
        p_vc[1] = 16'h5555;
        load_prog(2, 0, 0);
        do_reload();

        for (int r = 0; r < 6; r++) begin
            rand_fields();
            load_prog(int'($urandom_range(1, 16)), 2, r[0]);
            do_reload();
        end

        rand_fields();
        load_prog(4, 0, 1);
        do_reload();

        // Asynchronous reset while the third word is on the write port.
        rand_fields();
        found = 0;
        k = 0;
        in_valid_a = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (wr_a && addr_a == 9'd2) begin found = 1; break; end
            drive_fields(k % 5, 1'b0);
            k++;
            @(negedge clock);
        end
        chk("mid_found", found, 1);
        chk("mid_count_pre", count_a, 3);
        #2;
        reset = 1'b1;
        in_valid_a = 1'b0;
        #1;
        chk("mid_wr", wr_a, 0);
        chk("mid_working", working_a, 0);
        chk("mid_count", count_a, 0);
        chk("mid_overflow", overflow_a, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        rand_fields();
        load_prog(2, 0, 0);

        // Small-depth instance: six bundles offered, no in_last.
        rand_fields();
        mon_addr_b.delete(); mon_data_b.delete(); mon_cyc_b.delete();
        work_cyc_b = -1;
        kb = 0;
        acc_b = 0;
        cyc0 = cyc;
        for (int c = 0; c < 10; c++) begin
            drive_fields(kb, 1'b0);
            in_valid_b = 1'b1;
            if (in_ready_b) begin
                acc_b++;
                if (kb < 5) kb++;
            end
            @(negedge clock);
        end
        in_valid_b = 1'b0;
        for (int t = 0; t < 40 && work_cyc_b < 0; t++) @(negedge clock);
        chk("b_accepts", acc_b, B_DEPTH);
        chk("b_write_count", mon_addr_b.size(), B_DEPTH);
        for (int i = 0; i < B_DEPTH && i < mon_addr_b.size(); i++) begin
            chk($sformatf("b_addr[%0d]", i), mon_addr_b[i], i);
            chk($sformatf("b_wdata[%0d]", i), mon_data_b[i], pack(i));
            chk($sformatf("b_wr_cycle[%0d]", i), mon_cyc_b[i], cyc0 + 1 + i);
        end
        chk("b_working_cycle", work_cyc_b, cyc0 + B_DEPTH + SD + 1);
        chk("b_count", count_b, B_DEPTH);
        chk("b_overflow", overflow_b, 1);
        chk("b_ready", in_ready_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side counterpart of the processor fetch/decode path.
- Accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready stream and packs each into a 32-bit instruction word.
- Writes the words into sequential RAM addresses from 0 through the ram write port (addr/wr/wdata).
- After the last word, waits a programmable gap, then asserts working so the processor fetches from PC 0.

Parameters:
- ADDR_W, 9, RAM address width.
- DEPTH, 512, number of instruction words; must be ≤ 2^ADDR_W.
- START_DELAY, 2, idle cycles between the final write and working rising (≥1).

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle this cycle
- in_icode  in  4  instruction code
- in_ifun  in  4  function code
- in_rA  in  4  register A
- in_rB  in  4  register B
- in_valC  in  16  immediate
- in_last  in  1  bundle is the final instruction of the program
- reload  in  1  single-cycle pulse; in RUN, returns to LOAD for a new program
- addr  out  ADDR_W  RAM address (drives the processor's addr input)
- wr  out  1  RAM write strobe
- wdata  out  32  packed instruction word
- working  out  1  processor run enable
- count  out  ADDR_W+1  words written in current program
- overflow  out  1  sticky: in_valid seen while not in LOAD (word dropped)

Behaviour:
- Reset values: addr=0, wr=0, wdata=0, working=0, count=0, overflow=0, in_ready=0 while reset is high. State=LOAD; internal write pointer=0. RAM contents are not touched.
- Packing: wdata = {icode[31:28], ifun[27:24], rA[23:20], rB[19:16], valC[15:0]}. No sign extension, no field checking.
- States:
  - LOAD: in_ready=1 when count<DEPTH.
  - FLUSH: final write on the port.
  - WAIT: counter counts START_DELAY cycles.
  - RUN: working=1.
- Transfer: occurs on a posedge with in_valid & in_ready. The next cycle drives wr=1, addr=pointer, wdata=packed word, and count increments by 1. Latency is 1 cycle from acceptance to write strobe; the RAM samples on the following posedge. Back-to-back acceptance gives one write per cycle.
- No transfer in a LOAD cycle: next cycle wr=0; addr and wdata hold their last values.
- LOAD→FLUSH: on a transfer with in_last=1, or a transfer making count==DEPTH (implicit last).
- FLUSH→WAIT: after one cycle with wr=1. In WAIT: wr=0, addr=0, wdata=0, in_ready=0.
- WAIT→RUN: after exactly START_DELAY cycles in WAIT. working stays 1 until reset or reload; addr stays 0 and wr stays 0 in RUN.
- RUN→LOAD: on reload=1. working drops the next cycle; pointer and count clear to 0; overflow clears. reload in any other state is ignored.
- overflow: set when in_valid=1 in FLUSH/WAIT/RUN or when count==DEPTH. Sticky until reset or reload. Dropped data is never written.
- Zero-length program: not possible; at least one transfer is required to leave LOAD.
- Asynchronous reset mid-write: wr drops immediately. A partially loaded program is abandoned and the next load restarts at address 0.
- Pointer wraparound cannot occur: DEPTH caps count.

Test Plan:
- Load five bundles (1,0,F,0,0x0010), (2,0,0,1,0), (2,1,2,3,0), (2,2,4,5,0), (2,3,6,7,0 with last), with in_valid held continuously. Expected: writes to addr 0..4 with wdata 0x10F00010, 0x20010000, 0x21230000, 0x22450000, 0x23670000 on consecutive cycles; count=5; working rises exactly START_DELAY+1 cycles after the last wr.
- Gapped in_valid (one bundle every 3 cycles, 3 words): wr pulses are isolated single cycles one cycle after each acceptance; addresses are 0,1,2 with no gaps or duplicates.
- DEPTH=4 override, 6 bundles with no in_last: 4 writes at addr 0..3, then in_ready=0, implicit last, working=1, overflow=1, and no write to addr 4.
- In RUN, pulse reload, then load a 2-word program (0xAAAA then last 0x5555 as valC): working falls one cycle after reload; count restarts at 0; writes go to addr 0 and 1.
- Assert reset asynchronously between clock edges during the 3rd write of a 5-word load: wr, working, count, and overflow are 0 immediately. A subsequent load begins at addr 0.
- Drive in_valid during WAIT: overflow=1, no wr pulse, and working timing is unchanged.
